// File: rtl/load_align_unit.sv
// RV32 load alignment unit: issues word-aligned reads and byte/halfword-extracts the result.
// Optional misaligned-load trap is enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [4:0]  ld_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        accept, accept_fault;
  logic        mem_req_d, wb_valid_d, wb_fault_d;
  logic [31:0] mem_addr_d, wb_data_d;
  logic [4:0]  wb_rd_d;

  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      3'b010:  r = rdata;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign ld_ready = (state == IDLE);
  assign accept   = ld_valid && ld_ready;

  always_comb begin
    accept_fault = (ld_funct3 == 3'b011) || (ld_funct3 == 3'b110) || (ld_funct3 == 3'b111);
`ifdef LOAD_MISALIGN_TRAP_EN
    if ((ld_funct3[1:0] == 2'b01 && ld_addr[0]) ||
        (ld_funct3 == 3'b010 && ld_addr[1:0] != 2'b00))
      accept_fault = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= 3'h0;
      off_q    <= 2'h0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      wb_valid <= 1'b0;
      wb_data  <= 32'h0;
      wb_rd    <= 5'h0;
      wb_fault <= 1'b0;
    end else begin
      state    <= next_state;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      wb_valid <= wb_valid_d;
      wb_data  <= wb_data_d;
      wb_rd    <= wb_rd_d;
      wb_fault <= wb_fault_d;
    end
  end

  // DONE spans two cycles: one to settle the registered result, one with the strobe up.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = accept_fault ? DONE : REQ;
      REQ:   if (flush) next_state = IDLE;
             else if (mem_gnt) next_state = WAIT;
      WAIT:  if (flush) next_state = DRAIN;
             else if (mem_rvalid) next_state = DONE;
      DRAIN: if (mem_rvalid) next_state = IDLE;
      DONE:  if (wb_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    funct3_d   = funct3_q;
    off_d      = off_q;
    mem_addr_d = mem_addr;
    wb_data_d  = wb_data;
    wb_rd_d    = wb_rd;
    wb_fault_d = wb_fault;
    mem_req_d  = (next_state == REQ);
    wb_valid_d = (state == DONE) && !wb_valid;
    if (accept) begin
      funct3_d   = ld_funct3;
      off_d      = ld_addr[1:0];
      mem_addr_d = {ld_addr[31:2], 2'b00};
      wb_rd_d    = ld_rd;
      wb_fault_d = accept_fault;
      wb_data_d  = 32'h0;
    end
    if (state == WAIT && !flush && mem_rvalid)
      wb_data_d = align_load(funct3_q, off_q, mem_rdata);
  end

endmodule
